// File: rtl/controle_rolhas.sv
// controle_rolhas
// Sequences the cork dispenser motor and keeps the cork inventory counts.
// The corks in the tray are counted in bandeja. The corks in dispenser
// stock are counted in estoque.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   AD           dispense request (level) from fsm_dispensador
//   rolha_usada  1-cycle pulse, one cork taken from the tray
//   reabastecer  1-cycle pulse, operator loads qtd_reab corks into stock
//   qtd_reab     number of corks added on reabastecer
//   CR           tray count <= LIMIAR_CR
//   BZ           tray is empty
//   motor        dispenser motor enable (registered)
//   sem_estoque  stock is empty
//   erro_vazio   1-cycle pulse, rolha_usada arrived while the tray was empty
//   bandeja      current tray count
//   estoque      current stock count
module controle_rolhas #(
    parameter int unsigned BANDEJA_MAX     = 20,
    parameter int unsigned BANDEJA_INICIAL = 20,
    parameter int unsigned LIMIAR_CR       = 5,
    parameter int unsigned LOTE            = 15,
    parameter int unsigned ESTOQUE_MAX     = 99,
    parameter int unsigned ESTOQUE_INICIAL = 99,
    parameter int unsigned T_MOTOR         = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       AD,
    input  logic       rolha_usada,
    input  logic       reabastecer,
    input  logic [6:0] qtd_reab,
    output logic       CR,
    output logic       BZ,
    output logic       motor,
    output logic       sem_estoque,
    output logic       erro_vazio,
    output logic [6:0] bandeja,
    output logic [6:0] estoque
);

    localparam logic [7:0] B_MAX  = 8'(BANDEJA_MAX);
    localparam logic [6:0] B_INI  = 7'(BANDEJA_INICIAL);
    localparam logic [7:0] LIMIAR = 8'(LIMIAR_CR);
    localparam logic [7:0] LOTE8  = 8'(LOTE);
    localparam logic [7:0] E_MAX  = 8'(ESTOQUE_MAX);
    localparam logic [6:0] E_INI  = 7'(ESTOQUE_INICIAL);
    localparam logic [7:0] T_M1   = 8'(T_MOTOR - 1);

    typedef enum logic [1:0] {OCIOSO, MOTOR, TRANSFERIR, AGUARDA} estado_t;

    estado_t    estado, estado_next;
    logic [7:0] timer, timer_next;
    logic [7:0] espaco, n, soma, b_calc, e_calc;
    logic       usada, motor_next, erro_next;
    logic [6:0] bandeja_next, estoque_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado     <= OCIOSO;
            timer      <= '0;
            motor      <= 1'b0;
            erro_vazio <= 1'b0;
            bandeja    <= B_INI;
            estoque    <= E_INI;
        end else begin
            estado     <= estado_next;
            timer      <= timer_next;
            motor      <= motor_next;
            erro_vazio <= erro_next;
            bandeja    <= bandeja_next;
            estoque    <= estoque_next;
        end
    end

    always_comb begin
        estado_next = estado;
        timer_next  = timer;
        case (estado)
            OCIOSO: begin
                if (AD && estoque != '0 && {1'b0, bandeja} < B_MAX) begin
                    estado_next = MOTOR;
                    timer_next  = T_M1;
                end
            end
            MOTOR: begin
                if (timer == '0) estado_next = TRANSFERIR;
                else             timer_next  = timer - 8'd1;
            end
            TRANSFERIR: estado_next = AGUARDA;
            AGUARDA:    if (!AD) estado_next = OCIOSO;
            default:    estado_next = OCIOSO;
        endcase
        // The motor register tracks the next state.
        // The motor is therefore high exactly during the MOTOR cycles.
        motor_next = (estado_next == MOTOR);
    end

    always_comb begin
        espaco = B_MAX - {1'b0, bandeja};
        n      = '0;
        if (estado == TRANSFERIR) begin
            n = LOTE8;
            if ({1'b0, estoque} < n) n = {1'b0, estoque};
            if (espaco < n)          n = espaco;
        end
        // A cork can be taken from the batch that lands in this same edge.
        // An empty-tray error is raised only when nothing is available.
        soma      = {1'b0, bandeja} + n;
        usada     = rolha_usada && (soma != '0);
        erro_next = rolha_usada && (soma == '0);
        b_calc    = soma - {7'b0, usada};
        if (b_calc > B_MAX) b_calc = B_MAX;
        e_calc = {1'b0, estoque} - n + (reabastecer ? {1'b0, qtd_reab} : 8'd0);
        if (e_calc > E_MAX) e_calc = E_MAX;
        bandeja_next = b_calc[6:0];
        estoque_next = e_calc[6:0];
    end

    assign CR          = ({1'b0, bandeja} <= LIMIAR);
    assign BZ          = (bandeja == '0);
    assign sem_estoque = (estoque == '0);

endmodule
